// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard controller.
//               Holds the mul/div timer state encoding, the hard-wired zero
//               register address and a helper that sizes the cycle timer.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    // Mul/div timer states
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // Register r0 is hard-wired to zero, so a write to it never creates a hazard
    localparam logic [4:0] c_REG_ZERO = 5'd0;

    // Timer width: clog2 of the longer mul/div occupancy (both are >= 2)
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Bundle between the pipeline datapath and the hazard controller.
//               master : pipeline side, supplies hazard sources, receives
//                        stall/bubble/redirect controls.
//               slave  : hazard controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    // Hazard sources
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_wreg_addr;
    logic              ex_muldiv_start;
    logic              ex_muldiv_is_div;
    logic              ex_branch_taken;
    logic              if_req;
    logic              if_ack;
    logic              mem_req;
    logic              mem_ack;

    // Pipeline controls
    logic              pc_stall;
    logic              pc_redirect;
    logic              if_id_stall;
    logic              id_ex_stall;
    logic              ex_mem_stall;
    logic              mem_wb_stall;
    logic              if_id_bubble;
    logic              id_ex_bubble;
    logic              ex_mem_bubble;
    logic              mem_wb_bubble;
    logic              muldiv_busy;
    logic              muldiv_done;
    logic [31:0]       perf_stall_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_wreg_addr,
               ex_muldiv_start, ex_muldiv_is_div, ex_branch_taken,
               if_req, if_ack, mem_req, mem_ack,
        input  pc_stall, pc_redirect, if_id_stall, id_ex_stall, ex_mem_stall,
               mem_wb_stall, if_id_bubble, id_ex_bubble, ex_mem_bubble,
               mem_wb_bubble, muldiv_busy, muldiv_done, perf_stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_wreg_addr,
               ex_muldiv_start, ex_muldiv_is_div, ex_branch_taken,
               if_req, if_ack, mem_req, mem_ack,
        output pc_stall, pc_redirect, if_id_stall, id_ex_stall, ex_mem_stall,
               mem_wb_stall, if_id_bubble, id_ex_bubble, ex_mem_bubble,
               mem_wb_bubble, muldiv_busy, muldiv_done, perf_stall_cnt
    );

endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_muldiv_timer.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_muldiv_timer
// Description : Occupancy timer for multi-cycle MULT/DIV in EX.
//               Ports: clk, rst, i_start, i_is_div, i_mem_wait in;
//                      o_md_stall, o_busy, o_done out.
//               IDLE -> BUSY on start (unless the pipe is frozen by a data-
//               memory wait), BUSY counts down to DONE, DONE waits for the
//               memory stage to drain before pulsing done and returning idle.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_muldiv_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_start,
    input  wire logic i_is_div,
    input  wire logic i_mem_wait,
    output logic      o_md_stall,
    output logic      o_busy,
    output logic      o_done
);

    localparam int              c_TW       = timer_width(MUL_CYCLES, DIV_CYCLES);
    localparam logic [c_TW-1:0] c_MUL_LOAD = c_TW'(MUL_CYCLES - 1);
    localparam logic [c_TW-1:0] c_DIV_LOAD = c_TW'(DIV_CYCLES - 1);
    localparam logic [c_TW-1:0] c_ONE      = c_TW'(1);

    md_state_t       r_state;
    md_state_t       w_state_nxt;
    logic [c_TW-1:0] r_timer;
    logic [c_TW-1:0] w_timer_nxt;
    logic            w_md_stall;
    logic            w_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MD_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_md_stall  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (i_start) begin
                    // The start cycle itself counts as the first stall cycle;
                    // a start seen while memory freezes EX is simply re-seen later.
                    w_md_stall = 1'b1;
                    if (!i_mem_wait) begin
                        w_state_nxt = MD_BUSY;
                        w_timer_nxt = i_is_div ? c_DIV_LOAD : c_MUL_LOAD;
                    end
                end
            end
            MD_BUSY: begin
                // The functional unit keeps computing even while memory stalls.
                w_md_stall  = 1'b1;
                w_timer_nxt = r_timer - c_ONE;
                if (r_timer <= c_ONE) begin
                    w_state_nxt = MD_DONE;
                end
            end
            MD_DONE: begin
                // Result is committed only when the pipe actually advances.
                if (!i_mem_wait) begin
                    w_done      = 1'b1;
                    w_state_nxt = MD_IDLE;
                end
            end
            default: begin
                w_state_nxt = MD_IDLE;
            end
        endcase
    end

    assign o_md_stall = w_md_stall;
    assign o_busy     = (r_state == MD_BUSY);
    assign o_done     = w_done;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Stall/bubble controller for the 5-stage MIPS32 pipeline.
//               Ports: clk, rst (sync, active-high) and hif (hazard_ctrl_if
//               slave) carrying hazard sources in and pipeline controls out.
//               Resolves data-memory wait, mul/div occupancy, load-use,
//               taken branch and fetch wait in fixed priority, and counts
//               PC-stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  wire logic     clk,
    input  wire logic     rst,
    hazard_ctrl_if.slave  hif
);

    localparam logic [REG_AW-1:0] c_ZERO_ADDR = REG_AW'(c_REG_ZERO);

    logic        w_mem_wait;
    logic        w_md_stall;
    logic        w_load_use;
    logic        w_fetch_wait;
    logic        w_md_busy;
    logic        w_md_done;

    logic        w_pc_stall;
    logic        w_pc_redirect;
    logic        w_if_id_stall;
    logic        w_id_ex_stall;
    logic        w_ex_mem_stall;
    logic        w_mem_wb_stall;
    logic        w_if_id_bubble;
    logic        w_id_ex_bubble;
    logic        w_ex_mem_bubble;
    logic        w_mem_wb_bubble;

    logic [31:0] r_perf_cnt;

    assign w_mem_wait   = hif.mem_req & ~hif.mem_ack;
    assign w_fetch_wait = hif.if_req & ~hif.if_ack;
    assign w_load_use   = hif.ex_mem_read && (hif.ex_wreg_addr != c_ZERO_ADDR) &&
                          ((hif.id_uses_rs && (hif.id_rs == hif.ex_wreg_addr)) ||
                           (hif.id_uses_rt && (hif.id_rt == hif.ex_wreg_addr)));

    hazard_ctrl_muldiv_timer #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_muldiv_timer (
        .clk        (clk),
        .rst        (rst),
        .i_start    (hif.ex_muldiv_start),
        .i_is_div   (hif.ex_muldiv_is_div),
        .i_mem_wait (w_mem_wait),
        .o_md_stall (w_md_stall),
        .o_busy     (w_md_busy),
        .o_done     (w_md_done)
    );

    // Priority mux: the oldest blocked stage wins; everything upstream of it
    // holds and the stage just downstream receives a bubble.
    always_comb begin
        w_pc_stall      = 1'b0;
        w_pc_redirect   = 1'b0;
        w_if_id_stall   = 1'b0;
        w_id_ex_stall   = 1'b0;
        w_ex_mem_stall  = 1'b0;
        w_mem_wb_stall  = 1'b0;
        w_if_id_bubble  = 1'b0;
        w_id_ex_bubble  = 1'b0;
        w_ex_mem_bubble = 1'b0;
        w_mem_wb_bubble = 1'b0;
        if (rst) begin
            // all controls quiet during reset
        end else if (w_mem_wait) begin
            w_pc_stall      = 1'b1;
            w_if_id_stall   = 1'b1;
            w_id_ex_stall   = 1'b1;
            w_ex_mem_stall  = 1'b1;
            w_mem_wb_bubble = 1'b1;
        end else if (w_md_stall) begin
            w_pc_stall      = 1'b1;
            w_if_id_stall   = 1'b1;
            w_id_ex_stall   = 1'b1;
            w_ex_mem_bubble = 1'b1;
        end else if (w_load_use) begin
            w_pc_stall      = 1'b1;
            w_if_id_stall   = 1'b1;
            w_id_ex_bubble  = 1'b1;
        end else if (hif.ex_branch_taken && w_fetch_wait) begin
            // Keep the branch in EX until the wrong-path fetch completes,
            // otherwise the redirect would race an outstanding fetch.
            w_pc_stall      = 1'b1;
            w_if_id_stall   = 1'b1;
            w_id_ex_stall   = 1'b1;
            w_ex_mem_bubble = 1'b1;
        end else if (hif.ex_branch_taken) begin
            w_pc_redirect   = 1'b1;
            w_if_id_bubble  = 1'b1;
        end else if (w_fetch_wait) begin
            w_pc_stall      = 1'b1;
            w_if_id_bubble  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cnt <= 32'd0;
        end else if (w_pc_stall) begin
            r_perf_cnt <= r_perf_cnt + 32'd1;
        end
    end

    assign hif.pc_stall       = w_pc_stall;
    assign hif.pc_redirect    = w_pc_redirect;
    assign hif.if_id_stall    = w_if_id_stall;
    assign hif.id_ex_stall    = w_id_ex_stall;
    assign hif.ex_mem_stall   = w_ex_mem_stall;
    assign hif.mem_wb_stall   = w_mem_wb_stall;
    assign hif.if_id_bubble   = w_if_id_bubble;
    assign hif.id_ex_bubble   = w_id_ex_bubble;
    assign hif.ex_mem_bubble  = w_ex_mem_bubble;
    assign hif.mem_wb_bubble  = w_mem_wb_bubble;
    assign hif.muldiv_busy    = w_md_busy & ~rst;
    assign hif.muldiv_done    = w_md_done & ~rst;
    assign hif.perf_stall_cnt = r_perf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Directed stimulus pushes
//               the hand-derived expected control vector and stall count for
//               each cycle into a queue; a monitor pops and compares on the
//               falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int REG_AW = 5;

    // Expected-vector bit positions
    localparam logic [11:0] PC_S    = 12'h800;
    localparam logic [11:0] RDR     = 12'h400;
    localparam logic [11:0] IFID_S  = 12'h200;
    localparam logic [11:0] IDEX_S  = 12'h100;
    localparam logic [11:0] EXMEM_S = 12'h080;
    localparam logic [11:0] MEMWB_S = 12'h040;
    localparam logic [11:0] IFID_B  = 12'h020;
    localparam logic [11:0] IDEX_B  = 12'h010;
    localparam logic [11:0] EXMEM_B = 12'h008;
    localparam logic [11:0] MEMWB_B = 12'h004;
    localparam logic [11:0] BUSY    = 12'h002;
    localparam logic [11:0] DONE    = 12'h001;
    localparam logic [11:0] NONE    = 12'h000;

    localparam logic [11:0] P_MEM = PC_S | IFID_S | IDEX_S | EXMEM_S | MEMWB_B;
    localparam logic [11:0] P_MD  = PC_S | IFID_S | IDEX_S | EXMEM_B;
    localparam logic [11:0] P_LU  = PC_S | IFID_S | IDEX_B;
    localparam logic [11:0] P_BRW = PC_S | IFID_S | IDEX_S | EXMEM_B;
    localparam logic [11:0] P_BR  = RDR | IFID_B;
    localparam logic [11:0] P_FW  = PC_S | IFID_B;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(REG_AW)) bus ();

    hazard_ctrl #(
        .REG_AW     (REG_AW),
        .MUL_CYCLES (4),
        .DIV_CYCLES (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hif (bus.slave)
    );

    typedef struct {
        logic [11:0] vec;
        logic [31:0] cnt;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] cnt_model = 32'd0;
    logic [11:0] obs;

    assign obs = {bus.pc_stall, bus.pc_redirect, bus.if_id_stall, bus.id_ex_stall,
                  bus.ex_mem_stall, bus.mem_wb_stall, bus.if_id_bubble, bus.id_ex_bubble,
                  bus.ex_mem_bubble, bus.mem_wb_bubble, bus.muldiv_busy, bus.muldiv_done};

    // Monitor: one expectation per cycle, compared mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (obs !== e.vec) begin
                errors++;
                $display("FAIL %s ctrl: got %b expected %b (pc,rdr,s:ifid,idex,exmem,memwb,b:ifid,idex,exmem,memwb,busy,done) t=%0t",
                         e.name, obs, e.vec, $time);
            end
            checks++;
            if (bus.perf_stall_cnt !== e.cnt) begin
                errors++;
                $display("FAIL %s perf_stall_cnt: got %0d expected %0d t=%0t",
                         e.name, bus.perf_stall_cnt, e.cnt, $time);
            end
        end
    end

    task automatic clear_inputs();
        bus.id_rs            = '0;
        bus.id_rt            = '0;
        bus.id_uses_rs       = 1'b0;
        bus.id_uses_rt       = 1'b0;
        bus.ex_mem_read      = 1'b0;
        bus.ex_wreg_addr     = '0;
        bus.ex_muldiv_start  = 1'b0;
        bus.ex_muldiv_is_div = 1'b0;
        bus.ex_branch_taken  = 1'b0;
        bus.if_req           = 1'b0;
        bus.if_ack           = 1'b0;
        bus.mem_req          = 1'b0;
        bus.mem_ack          = 1'b0;
    endtask

    // Issue one cycle: record what the DUT must show this cycle, then advance.
    task automatic cyc(input logic [11:0] v, input string nm);
        exp_t e;
        e.vec  = v;
        e.cnt  = cnt_model;
        e.name = nm;
        sb.push_back(e);
        if (rst)        cnt_model = 32'd0;
        else if (v[11]) cnt_model = cnt_model + 32'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        // Aggressive inputs during reset must not leak to the controls
        bus.mem_req         = 1'b1;
        bus.ex_muldiv_start = 1'b1;
        bus.ex_branch_taken = 1'b1;
        bus.if_req          = 1'b1;
        @(posedge clk);
        #1;
        cyc(NONE, "reset0");
        cyc(NONE, "reset1");

        rst = 1'b0;
        clear_inputs();
        cyc(NONE, "idle");

        // MULT: 4 stall cycles, then done pulse with start still high
        bus.ex_muldiv_start  = 1'b1;
        bus.ex_muldiv_is_div = 1'b0;
        cyc(P_MD, "mult_t0");
        for (int t = 1; t <= 3; t++) cyc(P_MD | BUSY, "mult_busy");
        cyc(DONE, "mult_done");
        clear_inputs();
        cyc(NONE, "mult_after");

        // DIV with a long data-memory wait covering the end of the timer
        bus.ex_muldiv_start  = 1'b1;
        bus.ex_muldiv_is_div = 1'b1;
        cyc(P_MD, "div_t0");
        cyc(P_MD | BUSY, "div_t1");
        cyc(P_MD | BUSY, "div_t2");
        bus.mem_req = 1'b1;
        bus.mem_ack = 1'b0;
        for (int t = 3; t <= 40; t++) cyc((t <= 31) ? (P_MEM | BUSY) : P_MEM, "div_memwait");
        bus.mem_ack = 1'b1;
        cyc(DONE, "div_done");
        clear_inputs();
        cyc(NONE, "div_after");

        // Load-use on rt
        bus.ex_mem_read  = 1'b1;
        bus.ex_wreg_addr = 5'd5;
        bus.id_rs        = 5'd3;
        bus.id_uses_rs   = 1'b1;
        bus.id_rt        = 5'd5;
        bus.id_uses_rt   = 1'b1;
        cyc(P_LU, "lu_rt");
        // Load into r0 never hazards
        bus.ex_wreg_addr = 5'd0;
        bus.id_rt        = 5'd0;
        cyc(NONE, "lu_r0");
        // Load-use on rs; then same address but rs not read
        bus.ex_wreg_addr = 5'd7;
        bus.id_rs        = 5'd7;
        bus.id_uses_rt   = 1'b0;
        cyc(P_LU, "lu_rs");
        bus.id_uses_rs   = 1'b0;
        cyc(NONE, "lu_unused");
        clear_inputs();

        // Taken branch, fetch acknowledged
        bus.ex_branch_taken = 1'b1;
        bus.if_req          = 1'b1;
        bus.if_ack          = 1'b1;
        cyc(P_BR, "br_ack");
        // Taken branch with fetch outstanding, held until ack
        bus.if_ack = 1'b0;
        for (int t = 0; t < 3; t++) cyc(P_BRW, "br_wait");
        bus.if_ack = 1'b1;
        cyc(P_BR, "br_ack2");
        clear_inputs();
        cyc(NONE, "br_after");

        // Memory wait outranks load-use
        bus.mem_req      = 1'b1;
        bus.ex_mem_read  = 1'b1;
        bus.ex_wreg_addr = 5'd9;
        bus.id_rs        = 5'd9;
        bus.id_uses_rs   = 1'b1;
        cyc(P_MEM, "mem_over_lu");
        clear_inputs();

        // Reset in the middle of BUSY: back to idle, no done, counter cleared
        bus.ex_muldiv_start = 1'b1;
        cyc(P_MD, "rstmid_t0");
        cyc(P_MD | BUSY, "rstmid_t1");
        rst = 1'b1;
        cyc(NONE, "rstmid_rst");
        rst = 1'b0;
        clear_inputs();
        cyc(NONE, "rstmid_idle0");
        cyc(NONE, "rstmid_idle1");

        // Ten fetch-wait cycles from a cleared counter
        bus.if_req = 1'b1;
        for (int t = 0; t < 10; t++) cyc(P_FW, "fetch_wait");
        clear_inputs();
        cyc(NONE, "fw_count");
        cyc(NONE, "fw_count2");

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: pending expectations %0d expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
